iob_sram_mp: RTL and testbench



---
 rtl/iob_sram_mp_pkg.sv | 10 +
 rtl/iob_arb_rr.sv | 45 ++++
 rtl/iob_sram_mp.sv | 103 ++++++++++
 tb/tb_iob_sram_mp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_sram_mp_pkg.sv
// Shared constants and helpers for the multi-port SRAM and its arbiter.
package iob_sram_mp_pkg;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Port id needs at least one bit even when there is a single port.
   function automatic int id_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/iob_arb_rr.sv
// N-input arbiter: fixed priority or round-robin, one-hot grant plus encoded id.
module iob_arb_rr
   import iob_sram_mp_pkg::*;
#(
   parameter int N    = 2,
   parameter int MODE = ARB_RR,
   parameter int IDW  = id_w(N)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_acc,
   input  logic [N-1:0]   i_req,
   output logic [N-1:0]   o_gnt,
   output logic [IDW-1:0] o_id
);
   logic [IDW-1:0] r_ptr;
   int             w_base;
   int             w_idx;
   logic           w_found;

   // Fixed priority is round-robin with the scan origin pinned at port 0.
   assign w_base = (MODE == ARB_RR) ? int'(r_ptr) : 0;

   always_comb begin
      o_gnt   = '0;
      o_id    = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 0; i < N; i++) begin
         w_idx = (w_base + i) % N;
         if (!w_found && i_req[w_idx]) begin
            w_found       = 1'b1;
            o_gnt[w_idx]  = 1'b1;
            o_id          = IDW'(w_idx);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_ptr <= '0;
      else if (i_acc)
         r_ptr <= IDW'((int'(o_id) + 1) % N);
   end
endmodule

// File: rtl/iob_sram_mp.sv
// N-port shared single-port byte-enable SRAM with arbitration, ready backpressure
// and a {is_read, port_id} tag pipeline routing read data back to the requester.
module iob_sram_mp
   import iob_sram_mp_pkg::*;
#(
   parameter int    N_PORTS  = 2,
   parameter int    DATA_W   = 32,
   parameter int    ADDR_W   = 13,
   parameter int    RD_LAT   = 1,
   parameter int    ARB_MODE = ARB_RR,
   parameter string HEXFILE  = "none"
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         cke_i,
   input  logic [N_PORTS-1:0]           p_avalid_i,
   input  logic [N_PORTS*ADDR_W-1:0]    p_addr_i,
   input  logic [N_PORTS*DATA_W-1:0]    p_wdata_i,
   input  logic [N_PORTS*DATA_W/8-1:0]  p_wstrb_i,
   output logic [DATA_W-1:0]            p_rdata_o,
   output logic [N_PORTS-1:0]           p_rvalid_o,
   output logic [N_PORTS-1:0]           p_ready_o
);
   localparam int IDW = id_w(N_PORTS);
   localparam int SW  = DATA_W / 8;

   logic [N_PORTS-1:0] w_gnt;
   logic [IDW-1:0]     w_id;
   logic               w_acc;
   logic               w_rd;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  w_wdata;
   logic [SW-1:0]      w_wstrb;

   // Any requester is always granted, so acceptance only needs a request and cke.
   assign w_acc     = cke_i & (|p_avalid_i);
   assign p_ready_o = {N_PORTS{cke_i}} & (~p_avalid_i | w_gnt);

   iob_arb_rr #(.N(N_PORTS), .MODE(ARB_MODE), .IDW(IDW)) u_arb (
      .i_clk (clk_i),
      .i_rst (arst_i),
      .i_acc (w_acc),
      .i_req (p_avalid_i),
      .o_gnt (w_gnt),
      .o_id  (w_id)
   );

   assign w_addr  = p_addr_i [int'(w_id)*ADDR_W +: ADDR_W];
   assign w_wdata = p_wdata_i[int'(w_id)*DATA_W +: DATA_W];
   assign w_wstrb = p_wstrb_i[int'(w_id)*SW     +: SW];
   assign w_rd    = ~|w_wstrb;

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_ram_q;

   // RAM contents survive reset; only the control path is cleared.
   always_ff @(posedge clk_i) begin
      if (w_acc) begin
         for (int b = 0; b < SW; b++)
            if (w_wstrb[b])
               r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
         r_ram_q <= r_mem[w_addr];
      end
   end

   logic [RD_LAT:1]          r_vld_pipe;
   logic [RD_LAT:1][IDW-1:0] r_id_pipe;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_vld_pipe <= '0;
         r_id_pipe  <= '0;
      end else if (cke_i) begin
         r_vld_pipe[1] <= w_acc & w_rd;
         r_id_pipe[1]  <= w_id;
         for (int s = 2; s <= RD_LAT; s++) begin
            r_vld_pipe[s] <= r_vld_pipe[s-1];
            r_id_pipe[s]  <= r_id_pipe[s-1];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_oreg
         logic [DATA_W-1:0] r_rdata;
         always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i)
               r_rdata <= '0;
            else if (cke_i)
               r_rdata <= r_ram_q;
         end
         assign p_rdata_o = r_rdata;
      end else begin : g_raw
         assign p_rdata_o = r_ram_q;
      end
   endgenerate

   always_comb begin
      p_rvalid_o = '0;
      if (r_vld_pipe[RD_LAT])
         p_rvalid_o[r_id_pipe[RD_LAT]] = 1'b1;
   end
endmodule

// File: tb/tb_iob_sram_mp.sv
// Two configurations side by side (RR/lat1 and fixed/lat2, 3 ports) checked
// every cycle against a transaction-level model, plus literal scenario checks.
module tb_iob_sram_mp;
   typedef struct { logic [7:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;
   typedef struct { int port; logic [31:0] data; int due; } pend_t;
   typedef struct { int port; logic [31:0] data; int cyc; } log_t;

   logic clk = 1'b0;
   logic rst, cke;
   logic [1:0][2:0]  av, rv, rdy;
   logic [1:0][23:0] addr_f;
   logic [1:0][95:0] wdat_f;
   logic [1:0][11:0] strb_f;
   logic [1:0][31:0] rd;

   always #5 clk = ~clk;

   for (genvar c = 0; c < 2; c++) begin : g_dut
      iob_sram_mp #(.N_PORTS(3), .DATA_W(32), .ADDR_W(8), .RD_LAT(c == 0 ? 1 : 2),
                    .ARB_MODE(c == 0 ? 1 : 0), .HEXFILE("none")) u_dut (
         .clk_i(clk), .arst_i(rst), .cke_i(cke),
         .p_avalid_i(av[c]), .p_addr_i(addr_f[c]), .p_wdata_i(wdat_f[c]), .p_wstrb_i(strb_f[c]),
         .p_rdata_o(rd[c]), .p_rvalid_o(rv[c]), .p_ready_o(rdy[c]));
   end

   req_t        mq [2][3][$];
   pend_t       pend [2][$];
   log_t        log_q [2][$];
   logic [31:0] mem [2][256];
   logic [31:0] pre [16];
   int          ptr [2];
   int          kcnt [2];
   int          acc_cyc [2][3];
   int          cyc = 0;
   logic        prev_cke = 1'b0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_gnt(input logic [2:0] req, input int mode, input int p0);
      if (req == 3'b000) return 3'b000;
      if (mode == 0) return req & (~req + 3'd1);
      for (int i = 0; i < 3; i++)
         if (req[(p0 + i) % 3]) return 3'b001 << ((p0 + i) % 3);
      return 3'b000;
   endfunction

   // Masters present their queue head and hold it until accepted.
   always @(posedge clk) begin
      #2;
      for (int c = 0; c < 2; c++)
         for (int p = 0; p < 3; p++)
            if (mq[c][p].size() > 0) begin
               av[c][p]             = 1'b1;
               addr_f[c][p*8 +: 8]  = mq[c][p][0].addr;
               wdat_f[c][p*32 +: 32] = mq[c][p][0].wdata;
               strb_f[c][p*4 +: 4]  = mq[c][p][0].strb;
            end else
               av[c][p] = 1'b0;
   end

   // Model and compare, once per cycle at the falling edge.
   always @(negedge clk) begin
      cyc++;
      for (int c = 0; c < 2; c++) begin
         int lat, mode, idx;
         logic [2:0] erv, g, erdy;
         logic [31:0] ed;
         logic [7:0] a;
         logic [3:0] s;
         lat  = (c == 0) ? 1 : 2;
         mode = (c == 0) ? 1 : 0;
         if (rst) begin pend[c].delete(); ptr[c] = 0; end
         while (pend[c].size() > 0 && pend[c][0].due < kcnt[c]) void'(pend[c].pop_front());
         erv = 3'b000; ed = '0;
         if (pend[c].size() > 0 && pend[c][0].due == kcnt[c]) begin
            erv = 3'b001 << pend[c][0].port;
            ed  = pend[c][0].data;
         end
         chk($sformatf("rvalid[c%0d]", c), 64'(rv[c]), 64'(erv));
         if (erv != 3'b000) chk($sformatf("rdata[c%0d]", c), 64'(rd[c]), 64'(ed));
         if (rv[c] != 3'b000 && prev_cke)
            log_q[c].push_back('{port: (rv[c][0] ? 0 : rv[c][1] ? 1 : 2), data: rd[c], cyc: cyc});
         g    = exp_gnt(av[c], mode, ptr[c]);
         erdy = cke ? (~av[c] | g) : 3'b000;
         chk($sformatf("ready[c%0d]", c), 64'(rdy[c]), 64'(erdy));
         if (cke && !rst && g != 3'b000) begin
            idx = g[0] ? 0 : g[1] ? 1 : 2;
            a = addr_f[c][idx*8 +: 8];
            s = strb_f[c][idx*4 +: 4];
            if (s == 4'h0)
               pend[c].push_back('{port: idx, data: mem[c][a], due: kcnt[c] + lat});
            else
               for (int b = 0; b < 4; b++)
                  if (s[b]) mem[c][a][8*b +: 8] = wdat_f[c][idx*32 + 8*b +: 8];
            ptr[c] = (idx + 1) % 3;
         end
         for (int p = 0; p < 3; p++)
            if (av[c][p] && rdy[c][p] && cke && mq[c][p].size() > 0) begin
               void'(mq[c][p].pop_front());
               acc_cyc[c][p] = cyc;
            end
         if (cke && !rst) kcnt[c]++;
      end
      prev_cke = cke & ~rst;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_all(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      req_t r;
      r.addr = a; r.wdata = d; r.strb = s;
      for (int c = 0; c < 2; c++) mq[c][p].push_back(r);
   endtask

   task automatic clear_logs();
      for (int c = 0; c < 2; c++) log_q[c].delete();
   endtask

   function automatic bit busy();
      for (int c = 0; c < 2; c++) begin
         if (pend[c].size() > 0) return 1'b1;
         for (int p = 0; p < 3; p++) if (mq[c][p].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic wait_idle(input string nm);
      int n = 0;
      do begin tick(); n++; end while (busy() && n < 400);
      if (busy()) begin
         checks++; errors++;
         $display("FAIL %s: timeout waiting for idle, got busy expected idle", nm);
         for (int c = 0; c < 2; c++) for (int p = 0; p < 3; p++) mq[c][p].delete();
      end
      tick(); tick();
   endtask

   task automatic wait_acc0(input string nm);
      int n = 0;
      do begin tick(); n++; end while ((mq[0][0].size() > 0 || mq[1][0].size() > 0) && n < 20);
      if (mq[0][0].size() > 0 || mq[1][0].size() > 0) begin
         checks++; errors++;
         $display("FAIL %s: request not accepted, got pending expected accepted", nm);
      end
   endtask

   initial begin
      int exp_port [8];
      rst = 1'b1; cke = 1'b1;
      av = '0; addr_f = '0; wdat_f = '0; strb_f = '0;
      tick(); tick();
      @(negedge clk); #1;
      for (int c = 0; c < 2; c++) begin
         chk("reset_rvalid", 64'(rv[c]), 64'h0);
         chk("reset_ready_idle", 64'(rdy[c]), 64'h7);
      end
      tick(); rst = 1'b0; tick();

      // Write then read back-to-back on port 0.
      clear_logs();
      push_all(0, 8'd5, 32'hDEADBEEF, 4'hF);
      push_all(0, 8'd5, 32'h0, 4'h0);
      wait_idle("t1");
      for (int c = 0; c < 2; c++) begin
         chk("t1_count", 64'(log_q[c].size()), 64'd1);
         if (log_q[c].size() > 0) begin
            chk("t1_port", 64'(log_q[c][0].port), 64'd0);
            chk("t1_data", 64'(log_q[c][0].data), 64'hDEADBEEF);
            chk("t1_latency", 64'(log_q[c][0].cyc - acc_cyc[c][0]), 64'(c == 0 ? 1 : 2));
         end
      end

      // Byte strobes.
      clear_logs();
      push_all(0, 8'd7, 32'h11223344, 4'hF);
      push_all(0, 8'd7, 32'hAA000000, 4'h8);
      push_all(0, 8'd7, 32'h0, 4'h0);
      wait_idle("t2");
      for (int c = 0; c < 2; c++)
         if (log_q[c].size() == 1) chk("t2_strobe", 64'(log_q[c][0].data), 64'hAA223344);
         else chk("t2_count", 64'(log_q[c].size()), 64'd1);

      for (int a = 0; a < 16; a++) begin
         pre[a] = $urandom;
         push_all(2, 8'(a), pre[a], 4'hF);
      end
      push_all(2, 8'd20, 32'h5A5AC3C3, 4'hF);
      wait_idle("preload");

      // Back-to-back reads on port 1.
      clear_logs();
      for (int a = 0; a < 8; a++) push_all(1, 8'(a), 32'h0, 4'h0);
      wait_idle("b2b");
      for (int c = 0; c < 2; c++) begin
         chk("b2b_count", 64'(log_q[c].size()), 64'd8);
         if (log_q[c].size() == 8) begin
            chk("b2b_latency", 64'(log_q[c][7].cyc - acc_cyc[c][1]), 64'(c == 0 ? 1 : 2));
            for (int i = 0; i < 8; i++) begin
               chk("b2b_port", 64'(log_q[c][i].port), 64'd1);
               chk("b2b_data", 64'(log_q[c][i].data), 64'(pre[i]));
               chk("b2b_nobubble", 64'(log_q[c][i].cyc - log_q[c][0].cyc), 64'(i));
            end
         end
      end

      // Clock-enable stall with a read in flight.
      clear_logs();
      push_all(0, 8'd20, 32'h0, 4'h0);
      wait_acc0("stall_acc");
      cke = 1'b0;
      tick(); tick(); tick();
      cke = 1'b1;
      wait_idle("stall");
      for (int c = 0; c < 2; c++) begin
         chk("stall_count", 64'(log_q[c].size()), 64'd1);
         if (log_q[c].size() == 1) begin
            chk("stall_data", 64'(log_q[c][0].data), 64'h5A5AC3C3);
            chk("stall_latency", 64'(log_q[c][0].cyc - acc_cyc[c][0]), 64'(c == 0 ? 1 : 5));
         end
      end

      // Reset with a read in flight.
      clear_logs();
      push_all(0, 8'd20, 32'h0, 4'h0);
      wait_acc0("rst_acc");
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      for (int c = 0; c < 2; c++) chk("rst_dropped", 64'(log_q[c].size()), 64'd0);

      // Round-robin order straight after reset (pointer must restart at 0).
      clear_logs();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 3; p++) push_all(p, 8'(p + 1), 32'h0, 4'h0);
      wait_idle("rr");
      for (int c = 0; c < 2; c++) begin
         chk("rr_count", 64'(log_q[c].size()), 64'd6);
         if (log_q[c].size() == 6)
            for (int i = 0; i < 6; i++) begin
               int ep;
               ep = (c == 0) ? (i % 3) : (i / 2);
               chk($sformatf("rr_port[c%0d]", c), 64'(log_q[c][i].port), 64'(ep));
               chk("rr_data", 64'(log_q[c][i].data), 64'(pre[ep + 1]));
            end
      end

      // Fixed priority starvation.
      clear_logs();
      for (int a = 0; a < 6; a++) push_all(0, 8'(a), 32'h0, 4'h0);
      push_all(1, 8'd6, 32'h0, 4'h0);
      push_all(2, 8'd7, 32'h0, 4'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("fixed_starve_ready", 64'(rdy[1]), 64'h1);
      end
      wait_idle("fixed");
      exp_port = '{0, 0, 0, 0, 0, 0, 1, 2};
      chk("fixed_count", 64'(log_q[1].size()), 64'd8);
      if (log_q[1].size() == 8)
         for (int i = 0; i < 8; i++) begin
            chk("fixed_port", 64'(log_q[1][i].port), 64'(exp_port[i]));
            chk("fixed_data", 64'(log_q[1][i].data), 64'(pre[i]));
         end

      // Random traffic with random clock-enable gaps.
      for (int t = 0; t < 400; t++) begin
         cke = ($urandom_range(0, 7) != 0);
         for (int p = 0; p < 3; p++)
            if (mq[0][p].size() < 3 && $urandom_range(0, 1) == 1)
               push_all(p, 8'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
         tick();
      end
      cke = 1'b1;
      wait_idle("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
